// File: rtl/zeptron_pkg.sv
// Shared types for the Zeptron decode->execute boundary.
//   ctrl_t       : decoded control bundle carried down the pipe
//   CTRL_BUBBLE  : all-zero control word (no regfile write, no store, no branch/jump)
//   pipe_state_e : occupancy of the two-entry id/ex pipeline register
package zeptron_pkg;

    localparam int ALU_OP_W      = 4;
    localparam int ALU_SRCA_W    = 2;
    localparam int IMMG_OP_W     = 3;
    localparam int MEM_D_WDSRC_W = 2;
    localparam int DATAOUT_SRC_W = 2;
    localparam int BJ_OP_W       = 4;

    typedef struct packed {
        logic [ALU_OP_W-1:0]      alu_op;
        logic [ALU_SRCA_W-1:0]    alu_srca;
        logic                     alu_srcb;
        logic [IMMG_OP_W-1:0]     immg_op;
        logic [MEM_D_WDSRC_W-1:0] mem_d_wdsrc;
        logic                     mem_d_we;
        logic [DATAOUT_SRC_W-1:0] dataout_src;
        logic                     reg_we;
        logic [BJ_OP_W-1:0]       bj_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // output invalid, skid empty
        FULL  = 2'd1,   // output valid, skid empty
        SKID  = 2'd2    // output valid, skid holds the younger entry
    } pipe_state_e;

endpackage

// File: rtl/id_ex_pipe.sv
// Decode->execute pipeline register with a two-entry skid buffer.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the sender holds its payload stable until that edge, and the
// receiver may not depend on valid to produce ready.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               kill every held entry (redirect from execute)
//   id_valid/id_ready   decode-side handshake; id_ready comes from a flop
//   id_ctrl..id_rd      decoded instruction payload
//   ex_valid/ex_ready   execute-side handshake
//   ex_ctrl..ex_rd      registered payload; ex_ctrl forced to bubble when invalid
//   dbg_state           current occupancy state, for observation only
module id_ex_pipe
    import zeptron_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REGIDX_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  ctrl_t               id_ctrl,
    input  logic [XLEN-1:0]     id_pc,
    input  logic [XLEN-1:0]     id_rs1_data,
    input  logic [XLEN-1:0]     id_rs2_data,
    input  logic [XLEN-1:0]     id_imm,
    input  logic [REGIDX_W-1:0] id_rd,
    output logic                ex_valid,
    input  logic                ex_ready,
    output ctrl_t               ex_ctrl,
    output logic [XLEN-1:0]     ex_pc,
    output logic [XLEN-1:0]     ex_rs1_data,
    output logic [XLEN-1:0]     ex_rs2_data,
    output logic [XLEN-1:0]     ex_imm,
    output logic [REGIDX_W-1:0] ex_rd,
    output pipe_state_e         dbg_state
);

    typedef struct packed {
        ctrl_t                ctrl;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      rs1;
        logic [XLEN-1:0]      rs2;
        logic [XLEN-1:0]      imm;
        logic [REGIDX_W-1:0]  rd;
    } entry_t;

    pipe_state_e state_q, state_d;
    entry_t      out_q, skid_q, in_entry;
    logic        id_ready_q;
    logic        accept, emit;
    logic        load_out_in, load_out_skid, load_skid;

    assign in_entry = '{ctrl: id_ctrl, pc: id_pc, rs1: id_rs1_data,
                        rs2: id_rs2_data, imm: id_imm, rd: id_rd};

    assign accept = id_valid & id_ready_q;
    assign emit   = (state_q != EMPTY) & ex_ready;

    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            // Redirect wins over everything; whatever decode offers now is dropped.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        load_out_in = 1'b1;
                        state_d     = FULL;
                    end
                end
                FULL: begin
                    if (accept && emit) begin
                        load_out_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = SKID;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    // id_ready is low here, so no accept can occur.
                    if (emit) begin
                        load_out_skid = 1'b1;
                        state_d       = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            id_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            // Registered copy of (state != SKID) keeps id_ready off any comb path.
            id_ready_q <= (state_d != SKID);
            if (load_out_in) begin
                out_q <= in_entry;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    assign id_ready    = id_ready_q;
    assign ex_valid    = (state_q != EMPTY);
    assign ex_ctrl     = ex_valid ? out_q.ctrl : CTRL_BUBBLE;
    assign ex_pc       = out_q.pc;
    assign ex_rs1_data = out_q.rs1;
    assign ex_rs2_data = out_q.rs2;
    assign ex_imm      = out_q.imm;
    assign ex_rd       = out_q.rd;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios plus a short random
// valid/ready phase. A single negedge process acts as monitor and scoreboard.
module tb_id_ex_pipe;
  import zeptron_pkg::*;

  localparam int XLEN     = 32;
  localparam int REGIDX_W = 5;
  localparam int EW       = $bits(ctrl_t) + 4 * XLEN + REGIDX_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                id_valid;
  logic                id_ready;
  ctrl_t               id_ctrl;
  logic [XLEN-1:0]     id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REGIDX_W-1:0] id_rd;
  logic                ex_valid;
  logic                ex_ready;
  ctrl_t               ex_ctrl;
  logic [XLEN-1:0]     ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REGIDX_W-1:0] ex_rd;
  pipe_state_e         dbg_state;

  id_ex_pipe #(.XLEN(XLEN), .REGIDX_W(REGIDX_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_ctrl(id_ctrl),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ctrl(ex_ctrl),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            emit_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_out;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_in();
    return {id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rd};
  endfunction

  function automatic logic [EW-1:0] pack_out();
    return {ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd};
  endfunction

  function automatic ctrl_t mk_ctrl(input logic [31:0] s);
    ctrl_t c;
    c             = '0;
    c.alu_op      = s[5:2];
    c.alu_srca    = s[7:6];
    c.alu_srcb    = s[8];
    c.immg_op     = s[11:9];
    c.mem_d_wdsrc = s[3:2];
    c.mem_d_we    = s[4];
    c.dataout_src = s[6:5];
    c.reg_we      = 1'b1;
    c.bj_op       = s[9:6];
    return c;
  endfunction

  // Monitor + scoreboard. The queue holds exactly the entries the DUT should
  // currently be holding, oldest first.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("ex_valid_occ", ex_valid, exp_q.size() != 0);
      check("id_ready_occ", id_ready, exp_q.size() < 2);
      if (!ex_valid) check("bubble_ctrl", ex_ctrl, CTRL_BUBBLE);
      if (prev_stall) check("stall_stable", pack_out(), prev_out);
      if (ex_valid && ex_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 1'b1, 1'b0);
        else check("ex_payload", pack_out(), exp_q.pop_front());
        emit_cnt++;
      end
      prev_stall = ex_valid & !ex_ready & !flush;
      prev_out   = pack_out();
      if (flush) exp_q.delete();
      else if (id_valid && id_ready) exp_q.push_back(pack_in());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_instr(input logic [31:0] pc, input ctrl_t c);
    id_ctrl     = c;
    id_pc       = pc;
    id_rs1_data = pc * 3;
    id_rs2_data = ~pc;
    id_imm      = pc + 32'd16;
    id_rd       = pc[6:2];
  endtask

  // Offer one instruction starting now (posedge+1) and return #1 after the
  // edge that accepted it.
  task automatic issue(input logic [31:0] pc, input ctrl_t c);
    logic rdy;
    int   n;
    set_instr(pc, c);
    id_valid = 1'b1;
    n = 0;
    do begin
      rdy = id_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 20);
    if (!rdy) check("issue_timeout", 1'b0, 1'b1);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0;
    int t0;
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
    set_instr(32'h0, '0);
    #1;
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_id_ready", id_ready, 1'b1);
    check("rst_ex_ctrl", ex_ctrl, CTRL_BUBBLE);
    check("rst_ex_pc", ex_pc, 32'h0);
    check("rst_state", dbg_state, EMPTY);
    cycles(2);
    rst = 1'b0;
    cycles(1);

    // Streaming: 8 back-to-back at full throughput.
    ex_ready = 1'b1;
    e0 = emit_cnt;
    t0 = $time;
    for (int i = 0; i < 8; i++) issue(32'h200 + 4 * i, mk_ctrl(32'h200 + 4 * i));
    check("stream_cycles", ($time - t0) / 10, 8);
    id_valid = 1'b0;
    cycles(1);
    check("stream_emits", emit_cnt - e0, 8);
    check("stream_drained", exp_q.size(), 0);

    // Backpressure: two accepts into a stalled stage.
    ex_ready = 1'b0;
    issue(32'h100, mk_ctrl(32'h100));
    check("bp_ready_after_1st", id_ready, 1'b1);
    issue(32'h104, mk_ctrl(32'h104));
    id_valid = 1'b0;
    check("bp_ready_drop", id_ready, 1'b0);
    check("bp_state_skid", dbg_state, SKID);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_pc", ex_pc, 32'h100);
      cycles(1);
    end
    e0 = emit_cnt;
    ex_ready = 1'b1;
    check("bp_first_pc", ex_pc, 32'h100);
    cycles(1);
    check("bp_second_pc", ex_pc, 32'h104);
    check("bp_ready_back", id_ready, 1'b1);
    cycles(2);
    check("bp_emits", emit_cnt - e0, 2);
    check("bp_empty", ex_valid, 1'b0);

    // Flush while SKID with a concurrent offer.
    ex_ready = 1'b0;
    issue(32'h300, mk_ctrl(32'h300));
    issue(32'h304, mk_ctrl(32'h304));
    set_instr(32'h308, mk_ctrl(32'h308));
    id_valid = 1'b1;
    flush    = 1'b1;
    cycles(1);
    flush    = 1'b0;
    id_valid = 1'b0;
    check("fl_ex_valid", ex_valid, 1'b0);
    check("fl_id_ready", id_ready, 1'b1);
    check("fl_ex_ctrl", ex_ctrl, CTRL_BUBBLE);
    e0 = emit_cnt;
    ex_ready = 1'b1;
    cycles(3);
    check("fl_no_emit", emit_cnt - e0, 0);

    // Bubble: a store+writeback instruction accepted during flush is dropped.
    ex_ready = 1'b0;
    issue(32'h400, mk_ctrl(32'h410));
    set_instr(32'h404, mk_ctrl(32'h414));
    id_valid = 1'b1;
    flush    = 1'b1;
    cycles(1);
    flush    = 1'b0;
    id_valid = 1'b0;
    check("bub_ex_valid", ex_valid, 1'b0);
    check("bub_ctrl", ex_ctrl, 19'h0);
    e0 = emit_cnt;
    ex_ready = 1'b1;
    cycles(3);
    check("bub_no_emit", emit_cnt - e0, 0);

    // Reset mid-traffic (asynchronous).
    ex_ready = 1'b0;
    issue(32'h500, mk_ctrl(32'h500));
    issue(32'h504, mk_ctrl(32'h504));
    id_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mrst_ex_valid", ex_valid, 1'b0);
    check("mrst_ex_ctrl", ex_ctrl, CTRL_BUBBLE);
    check("mrst_id_ready", id_ready, 1'b1);
    check("mrst_ex_pc", ex_pc, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycles(1);

    // Random valid/ready traffic, then drain.
    for (int i = 0; i < 80; i++) begin
      ex_ready = 1'($urandom_range(0, 1));
      id_valid = 1'($urandom_range(0, 1));
      set_instr(32'h1000 + 4 * i, mk_ctrl($urandom_range(0, 4095)));
      cycles(1);
    end
    id_valid = 1'b0;
    ex_ready = 1'b1;
    cycles(4);
    check("rand_drained", exp_q.size(), 0);
    check("rand_idle", ex_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
